uart_cmd_regfile: RTL and testbench
===================================

# uart_cmd_regfile

Command decoder and register bank directly downstream of the UART wrapper. It consumes each 32-bit word assembled by the UART receive path (`uart_rx_reg` qualified by `uart_rx_ready`) and decodes it as a read or write command. Writes update a bank of 16-bit control registers; reads, writes and errors produce a 32-bit response word pushed back into the UART transmit FIFO via `uart_tx_reg`/`uart_tx_en`. Register contents drive design configuration through a flattened output bus.

## Interface
Parameters:
- `NUM_REGS`, 16: number of 16-bit registers, legal range 2..256; address 0 is the read-only version register.
- `VERSION`, 16'h0100: constant value returned when reading address 0.

Ports:
- `sys_clk`  in  1: system clock; the block uses only this clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `uart_rx_reg`  in  32: received command word.
- `uart_rx_ready`  in  1: one-cycle strobe; `uart_rx_reg` is valid in that cycle.
- `uart_tx_reg`  out  32: response word.
- `uart_tx_en`  out  1: one-cycle push strobe into the TX FIFO.
- `reg_bank`  out  NUM_REGS*16: flattened registers; register n occupies bits [16n+15:16n]; slice 0 = `VERSION`.
- `reg_wr_strobe`  out  NUM_REGS: one-cycle pulse on bit n when register n is written.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `err_cnt`  out  8: count of NAKs and dropped commands; saturates at 8'hFF.

## Operation
- Command format: [31:24] opcode, [23:16] address, [15:0] write data.
- Opcodes:
  - 8'h01: write.
  - 8'h02: read.
  - Any other value: NAK with reason 8'h01.
- Error checks, applied in this priority:
  - Bad opcode → reason 8'h01.
  - Address ≥ `NUM_REGS` → reason 8'h02.
  - Write to address 0 → reason 8'h03.
- Response format: [31:24] status, [23:16] echoed address, [15:0] payload.
  - Read OK: status 8'h5A, payload = register value.
  - Write ACK: status 8'hA5, payload = the data written.
  - NAK: status 8'hEE, payload = {received opcode, reason}.
- FSM states: IDLE → DECODE → EXEC → RESP → IDLE.
  - IDLE: a `uart_rx_ready` strobe latches the command.
  - DECODE: classifies the command as read, write, or error with reason.
  - EXEC: performs the register write (pulsing the matching `reg_wr_strobe` bit) or the register read, and builds the response.
  - RESP: drives `uart_tx_en` for one cycle, or skips the push as described under Configuration.
- A strobe arriving while `busy` = 1 is dropped, not queued, and increments `err_cnt`. No response is generated for it.
- Each NAK increments `err_cnt` once. A NAK and a dropped strobe in the same cycle increment it by 2, saturating.
- `uart_tx_reg` holds its last value between pushes.

## Timing
- Reset values:
  - `uart_tx_reg` = 0, `uart_tx_en` = 0.
  - `reg_wr_strobe` = 0, `busy` = 0, `err_cnt` = 0.
  - Registers 1..NUM_REGS-1 = 16'h0000.
  - FSM returns to IDLE.
- Reset mid-command aborts the command: no write and no response.
- Cycle timing, with the strobe sampled at cycle T:
  - `busy` rises at T+1.
  - The register update and `reg_wr_strobe` are visible at T+3.
  - `uart_tx_en` is high during T+3, with `uart_tx_reg` valid in that same cycle.
  - `busy` falls at T+4.
- A new command is accepted at T+4 at the earliest. The UART byte rate guarantees spacing of more than 4 cycles; the TX FIFO is never checked for full.
- Read data is the register value before any write in the same command. Reads and writes never overlap.

## Configuration
- `UART_CMD_WR_ACK_EN` defined: successful writes push an A5 acknowledge response.
- Undefined: successful writes are silent. RESP completes without asserting `uart_tx_en`, and the same latency applies.
- Read responses and NAKs are always pushed, with or without the macro.

## Structure
- Shared package `uart_cmd_pkg` holds:
  - Opcode constants `CMD_WR` and `CMD_RD`.
  - Status constants `ST_RD_OK`, `ST_WR_ACK`, `ST_NAK`.
  - Reason codes `NAK_OPCODE`, `NAK_ADDR`, `NAK_RO`.
  - The FSM state enum.
  - Field bit-position constants.
- Sub-module `uart_cmd_decode` performs the combinational command classification and reason selection. The top level holds the FSM, the register bank, and the counter.

## Test plan
- Write 32'h0103_BEEF (with `UART_CMD_WR_ACK_EN` defined) → `reg_bank[63:48]` = BEEF, `reg_wr_strobe[3]` pulses at T+3, `uart_tx_en` pushes 32'hA503_BEEF.
- Read 32'h0200_0000 → push 32'h5A00_0100 (the `VERSION` value); read 32'h0203_0000 after the write above → push 32'h5A03_BEEF.
- Commands 32'h0110_1234 (with `NUM_REGS` = 16), 32'h0100_1234, and 32'h7F01_0000 → pushes 32'hEE10_0102, 32'hEE00_0103, and 32'hEE01_7F01 respectively; `err_cnt` = 3; no register changes.
- Second strobe at T+2 → no second response, `err_cnt` increments by 1, first command completes normally.
- Assert `rst_n` low at T+2 of a write → no `reg_wr_strobe`, no `uart_tx_en`, all outputs at reset values the cycle after reset; 300 NAKs → `err_cnt` holds at 8'hFF.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants, field positions and state/kind enums for the UART command register file.
// Successful-write acknowledge pushes are enabled by the UART_CMD_WR_ACK_EN macro (see top level).
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR     = 8'h01;
    localparam logic [7:0] CMD_RD     = 8'h02;

    localparam logic [7:0] ST_RD_OK   = 8'h5A;
    localparam logic [7:0] ST_WR_ACK  = 8'hA5;
    localparam logic [7:0] ST_NAK     = 8'hEE;

    localparam logic [7:0] NAK_OPCODE = 8'h01;
    localparam logic [7:0] NAK_ADDR   = 8'h02;
    localparam logic [7:0] NAK_RO     = 8'h03;

    // Command and response words share the same field layout
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 24;
    localparam int ADDR_MSB = 23;
    localparam int ADDR_LSB = 16;
    localparam int DATA_MSB = 15;
    localparam int DATA_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_READ  = 2'd0,
        K_WRITE = 2'd1,
        K_NAK   = 2'd2
    } cmd_kind_t;

endpackage

// File: rtl/uart_cmd_decode.sv
// Combinational command classifier: read, write, or NAK with the highest-priority reason code.
module uart_cmd_decode
    import uart_cmd_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic [7:0] i_opcode,
    input  logic [7:0] i_addr,
    output cmd_kind_t  o_kind,
    output logic [7:0] o_reason
);

    always_comb begin
        o_kind   = K_NAK;
        o_reason = 8'h00;
        if (i_opcode != CMD_WR && i_opcode != CMD_RD) begin
            o_reason = NAK_OPCODE;
        end else if (int'(i_addr) >= NUM_REGS) begin
            o_reason = NAK_ADDR;
        end else if (i_opcode == CMD_WR && i_addr == 8'h00) begin
            // address 0 is the version register and cannot be written
            o_reason = NAK_RO;
        end else if (i_opcode == CMD_WR) begin
            o_kind = K_WRITE;
        end else begin
            o_kind = K_READ;
        end
    end

endmodule

// File: rtl/uart_cmd_regfile.sv
// UART command decoder and 16-bit control register bank; IDLE->DECODE->EXEC->RESP per command.
// Define UART_CMD_WR_ACK_EN to push an A5 acknowledge for successful writes (silent otherwise).
module uart_cmd_regfile
    import uart_cmd_pkg::*;
#(
    parameter int          NUM_REGS = 16,
    parameter logic [15:0] VERSION  = 16'h0100
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic [31:0]              uart_rx_reg,
    input  logic                     uart_rx_ready,
    output logic [31:0]              uart_tx_reg,
    output logic                     uart_tx_en,
    output logic [NUM_REGS*16-1:0]   reg_bank,
    output logic [NUM_REGS-1:0]      reg_wr_strobe,
    output logic                     busy,
    output logic [7:0]               err_cnt
);

`ifdef UART_CMD_WR_ACK_EN
    localparam bit WR_ACK_PUSH = 1'b1;
`else
    localparam bit WR_ACK_PUSH = 1'b0;
`endif

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_busy;
    logic [31:0]            r_cmd;
    cmd_kind_t              r_kind;
    cmd_kind_t              w_kind;
    logic [7:0]             r_reason;
    logic [7:0]             w_reason;
    logic [31:0]            r_tx;
    logic                   r_push;
    logic [NUM_REGS-1:0]    r_strobe;
    logic [NUM_REGS-1:0]    w_strobe_next;
    logic [NUM_REGS*16-1:0] w_bank;
    logic [15:0]            w_rd_data;
    logic [7:0]             r_err;
    logic [1:0]             w_err_inc;
    logic [8:0]             w_err_sum;
    logic                   w_do_write;
    logic                   w_nak_now;
    logic                   w_drop;

    logic [7:0]  w_opcode;
    logic [7:0]  w_addr;
    logic [15:0] w_wdata;

    assign w_opcode = r_cmd[OPC_MSB:OPC_LSB];
    assign w_addr   = r_cmd[ADDR_MSB:ADDR_LSB];
    assign w_wdata  = r_cmd[DATA_MSB:DATA_LSB];

    uart_cmd_decode #(
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .i_opcode (w_opcode),
        .i_addr   (w_addr),
        .o_kind   (w_kind),
        .o_reason (w_reason)
    );

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:   if (uart_rx_ready) w_state_next = S_DECODE;
            S_DECODE: w_state_next = S_EXEC;
            S_EXEC:   w_state_next = S_RESP;
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    assign w_do_write = (r_state == S_EXEC) && (r_kind == K_WRITE);
    assign w_nak_now  = (r_state == S_EXEC) && (r_kind == K_NAK);
    assign w_drop     = uart_rx_ready && w_busy;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_cmd    <= 32'h0;
            r_kind   <= K_NAK;
            r_reason <= 8'h00;
        end else begin
            if (r_state == S_IDLE && uart_rx_ready) begin
                r_cmd <= uart_rx_reg;
            end
            if (r_state == S_DECODE) begin
                r_kind   <= w_kind;
                r_reason <= w_reason;
            end
        end
    end

    // Register 0 is the constant version word; 1..NUM_REGS-1 are writable
    assign w_bank[15:0]     = VERSION;
    assign w_strobe_next[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic [15:0] r_val;
            assign w_strobe_next[gi] = w_do_write && (w_addr == 8'(gi));
            always_ff @(posedge sys_clk) begin
                if (!rst_n) begin
                    r_val <= 16'h0000;
                end else if (w_strobe_next[gi]) begin
                    r_val <= w_wdata;
                end
            end
            assign w_bank[gi*16 +: 16] = r_val;
        end
    endgenerate

    always_comb begin
        w_rd_data = 16'h0000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_addr == 8'(i)) w_rd_data = w_bank[i*16 +: 16];
        end
    end

    // Response is built in EXEC; r_tx only changes when a push will follow
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_tx     <= 32'h0;
            r_push   <= 1'b0;
            r_strobe <= '0;
        end else begin
            r_strobe <= w_strobe_next;
            if (r_state == S_EXEC) begin
                case (r_kind)
                    K_READ: begin
                        r_tx   <= {ST_RD_OK, w_addr, w_rd_data};
                        r_push <= 1'b1;
                    end
                    K_WRITE: begin
                        r_push <= WR_ACK_PUSH;
                        if (WR_ACK_PUSH) r_tx <= {ST_WR_ACK, w_addr, w_wdata};
                    end
                    default: begin
                        r_tx   <= {ST_NAK, w_addr, w_opcode, r_reason};
                        r_push <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign w_err_inc = {1'b0, w_nak_now} + {1'b0, w_drop};
    assign w_err_sum = {1'b0, r_err} + {7'b0, w_err_inc};

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_err <= 8'h00;
        end else begin
            r_err <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end

    assign uart_tx_reg   = r_tx;
    assign uart_tx_en    = (r_state == S_RESP) && r_push;
    assign reg_bank      = w_bank;
    assign reg_wr_strobe = r_strobe;
    assign busy          = w_busy;
    assign err_cnt       = r_err;

endmodule

// File: tb/tb_uart_cmd_regfile.sv
// Directed bench for uart_cmd_regfile: writes, reads, NAKs, dropped strobes, mid-command reset, saturation.
module tb_uart_cmd_regfile;

    localparam int NUM_REGS = 16;

`ifdef UART_CMD_WR_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic                   sys_clk = 1'b0;
    logic                   rst_n;
    logic [31:0]            uart_rx_reg;
    logic                   uart_rx_ready;
    logic [31:0]            uart_tx_reg;
    logic                   uart_tx_en;
    logic [NUM_REGS*16-1:0] reg_bank;
    logic [NUM_REGS-1:0]    reg_wr_strobe;
    logic                   busy;
    logic [7:0]             err_cnt;

    int checks   = 0;
    int failures = 0;
    logic [NUM_REGS*16-1:0] bank_snap;

    always #5 sys_clk = ~sys_clk;

    uart_cmd_regfile #(
        .NUM_REGS (NUM_REGS),
        .VERSION  (16'h0100)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .uart_rx_reg   (uart_rx_reg),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_reg   (uart_tx_reg),
        .uart_tx_en    (uart_tx_en),
        .reg_bank      (reg_bank),
        .reg_wr_strobe (reg_wr_strobe),
        .busy          (busy),
        .err_cnt       (err_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Strobe at cycle T, then check every cycle through T+4
    task automatic do_cmd(input logic [31:0] cmd, input bit exp_push,
                          input logic [31:0] exp_word, input logic [15:0] exp_strb);
        @(negedge sys_clk);
        uart_rx_reg   = cmd;
        uart_rx_ready = 1'b1;
        @(negedge sys_clk);
        uart_rx_ready = 1'b0;
        check_eq("busy_t1", busy, 1);
        check_eq("txen_t1", uart_tx_en, 0);
        @(negedge sys_clk);
        check_eq("txen_t2", uart_tx_en, 0);
        check_eq("strb_t2", reg_wr_strobe, 0);
        @(negedge sys_clk);
        check_eq("txen_t3", uart_tx_en, exp_push);
        if (exp_push) check_eq("txword_t3", uart_tx_reg, exp_word);
        check_eq("strb_t3", reg_wr_strobe, exp_strb);
        $display("cmd %h -> tx_en=%0b tx=%h strobe=%h err=%0d", cmd, uart_tx_en, uart_tx_reg,
                 reg_wr_strobe, err_cnt);
        @(negedge sys_clk);
        check_eq("busy_t4", busy, 0);
        check_eq("txen_t4", uart_tx_en, 0);
        check_eq("strb_t4", reg_wr_strobe, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        uart_rx_reg   = 32'h0;
        uart_rx_ready = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_eq("rst_tx", uart_tx_reg, 32'h0);
        check_eq("rst_txen", uart_tx_en, 0);
        check_eq("rst_strb", reg_wr_strobe, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err_cnt, 0);
        check_eq("rst_ver", reg_bank[15:0], 32'h0100);
        check_eq("rst_bank_zero", (reg_bank[NUM_REGS*16-1:16] == '0), 1);
        rst_n = 1'b1;

        // Write, then reads of version and of the written register
        do_cmd(32'h0103_BEEF, ACK, 32'hA503_BEEF, 16'h0008);
        check_eq("reg3", reg_bank[63:48], 32'hBEEF);
        do_cmd(32'h0200_0000, 1'b1, 32'h5A00_0100, 16'h0000);
        do_cmd(32'h0203_0000, 1'b1, 32'h5A03_BEEF, 16'h0000);

        // NAKs: bad address, read-only address, bad opcode
        bank_snap = reg_bank;
        do_cmd(32'h0110_1234, 1'b1, 32'hEE10_0102, 16'h0000);
        do_cmd(32'h0100_1234, 1'b1, 32'hEE00_0103, 16'h0000);
        do_cmd(32'h7F01_0000, 1'b1, 32'hEE01_7F01, 16'h0000);
        check_eq("nak_err", err_cnt, 3);
        check_eq("nak_bank_same", (reg_bank == bank_snap), 1);

        // Second strobe at T+2 is dropped; the first write completes
        @(negedge sys_clk);
        uart_rx_reg   = 32'h0105_1234;
        uart_rx_ready = 1'b1;
        @(negedge sys_clk);
        uart_rx_ready = 1'b0;
        @(negedge sys_clk);
        uart_rx_reg   = 32'h0206_0000;
        uart_rx_ready = 1'b1;
        @(negedge sys_clk);
        uart_rx_ready = 1'b0;
        check_eq("drop_txen", uart_tx_en, ACK);
        if (ACK) check_eq("drop_txword", uart_tx_reg, 32'hA505_1234);
        check_eq("drop_strb", reg_wr_strobe, 32'h0020);
        check_eq("drop_err", err_cnt, 4);
        $display("cmd 01051234 + dropped 02060000 -> tx_en=%0b err=%0d", uart_tx_en, err_cnt);
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk);
            check_eq("drop_no_push", uart_tx_en, 0);
        end
        check_eq("drop_busy", busy, 0);
        check_eq("reg5", reg_bank[95:80], 32'h1234);

        // Reset asserted at T+2 of a write aborts it
        @(negedge sys_clk);
        uart_rx_reg   = 32'h0107_5555;
        uart_rx_ready = 1'b1;
        @(negedge sys_clk);
        uart_rx_ready = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b0;
        @(negedge sys_clk);
        check_eq("abort_strb", reg_wr_strobe, 0);
        check_eq("abort_txen", uart_tx_en, 0);
        check_eq("abort_tx", uart_tx_reg, 32'h0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_err", err_cnt, 0);
        check_eq("abort_reg7", reg_bank[127:112], 32'h0);
        check_eq("abort_reg3", reg_bank[63:48], 32'h0);
        $display("reset at T+2 of 01075555 -> tx_en=%0b strobe=%h", uart_tx_en, reg_wr_strobe);
        rst_n = 1'b1;
        @(negedge sys_clk);
        check_eq("abort_after_txen", uart_tx_en, 0);

        // 300 NAKs saturate the error counter
        for (int n = 1; n <= 300; n++) begin
            @(negedge sys_clk);
            uart_rx_reg   = 32'h7F01_0000;
            uart_rx_ready = 1'b1;
            @(negedge sys_clk);
            uart_rx_ready = 1'b0;
            repeat (4) @(negedge sys_clk);
            if (n == 100) check_eq("sat_100", err_cnt, 100);
            if (n == 255) check_eq("sat_255", err_cnt, 8'hFF);
        end
        check_eq("sat_300", err_cnt, 8'hFF);
        $display("300 NAKs -> err=%0d", err_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
